// File: rtl/edram_row_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : edram_row_ctrl_if
// Description : Host row-access handshake between a host and the eDRAM row
//               sequencer.
//               master : host side      (drives req_valid, req_row)
//               slave  : sequencer side (drives req_ready, acc_done)
//               Ports carried:
//                 req_valid  host requests a row activation
//                 req_row    host row address, sampled on accept
//                 req_ready  sequencer can accept this cycle
//                 acc_done   one-cycle pulse when a host activation finishes
// Revision    : 1.0 - initial release
// ============================================================================
interface edram_row_ctrl_if #(
   parameter int ROW_BITS = 8
);
   logic                req_valid;
   logic [ROW_BITS-1:0] req_row;
   logic                req_ready;
   logic                acc_done;

   modport master (
      output req_valid,
      output req_row,
      input  req_ready,
      input  acc_done
   );

   modport slave (
      input  req_valid,
      input  req_row,
      output req_ready,
      output acc_done
   );
endinterface
`default_nettype wire

// File: rtl/edram_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : edram_row_ctrl
// Description : Row-access sequencer and refresh scheduler for the 1 Mb eDRAM
//               array. Arbitrates host activations against periodic refresh,
//               times the wordline-active and precharge phases, and walks a
//               wrapping refresh row pointer.
//               Ports:
//                 clk, rst_n    clock, asynchronous active-low reset
//                 host          host handshake (slave side of the interface)
//                 row_addr      registered row address to the decoder
//                 decode_en     registered wordline enable
//                 ref_busy      high during a refresh activation + precharge
//                 pend_cnt      pending refresh count (saturating)
//                 ref_overflow  sticky: a refresh tick was lost at saturation
// Revision    : 1.0 - initial release
// ============================================================================
module edram_row_ctrl #(
   parameter int ROW_BITS = 8,
   parameter int REFI     = 64,
   parameter int T_ACT    = 3,
   parameter int T_PRE    = 2,
   parameter int PEND_MAX = 8
) (
   input  wire                              clk,
   input  wire                              rst_n,
   edram_row_ctrl_if.slave                  host,
   output logic [ROW_BITS-1:0]              row_addr,
   output logic                             decode_en,
   output logic                             ref_busy,
   output logic [$clog2(PEND_MAX+1)-1:0]    pend_cnt,
   output logic                             ref_overflow
);

   localparam int c_pend_bits = $clog2(PEND_MAX + 1);
   localparam int c_tmr_bits  = $clog2(REFI);
   localparam int c_ph_max    = (T_ACT > T_PRE) ? T_ACT : T_PRE;
   localparam int c_ph_bits   = $clog2(c_ph_max + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACT  = 2'd1,
      PRE  = 2'd2
   } state_t;

   state_t                  state_q,        state_d;
   logic [c_ph_bits-1:0]    ph_q,           ph_d;
   logic [c_tmr_bits-1:0]   timer_q,        timer_d;
   logic [c_pend_bits-1:0]  pend_cnt_q,     pend_cnt_d;
   logic                    ref_overflow_q, ref_overflow_d;
   logic [ROW_BITS-1:0]     ref_row_q,      ref_row_d;
   logic [ROW_BITS-1:0]     row_addr_q,     row_addr_d;
   logic                    decode_en_q,    decode_en_d;
   logic                    ref_busy_q,     ref_busy_d;
   logic                    acc_done_q,     acc_done_d;
   logic                    host_q,         host_d;   // current activation is a host access

   logic w_tick;
   logic w_pend_full;
   logic w_req_ready;
   logic w_ref_start;
   logic w_host_start;

   assign w_tick      = (timer_q == c_tmr_bits'(REFI - 1));
   assign w_pend_full = (pend_cnt_q == c_pend_bits'(PEND_MAX));
   assign w_req_ready = (state_q == IDLE) && !w_pend_full;

   // Arbitration in IDLE: a saturated refresh backlog beats the host, the host
   // beats a non-urgent backlog.
   always_comb begin
      w_ref_start  = 1'b0;
      w_host_start = 1'b0;
      if (state_q == IDLE) begin
         if (w_pend_full) begin
            w_ref_start = 1'b1;
         end else if (host.req_valid && w_req_ready) begin
            w_host_start = 1'b1;
         end else if (pend_cnt_q != '0) begin
            w_ref_start = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      ph_d           = ph_q;
      row_addr_d     = row_addr_q;
      decode_en_d    = decode_en_q;
      ref_busy_d     = ref_busy_q;
      acc_done_d     = 1'b0;
      host_d         = host_q;
      ref_row_d      = ref_row_q;
      timer_d        = w_tick ? '0 : timer_q + c_tmr_bits'(1);
      pend_cnt_d     = pend_cnt_q;
      ref_overflow_d = ref_overflow_q;

      case (state_q)
         IDLE: begin
            if (w_ref_start || w_host_start) begin
               state_d     = ACT;
               ph_d        = '0;
               decode_en_d = 1'b1;
               host_d      = w_host_start;
            end
            if (w_host_start) begin
               row_addr_d = host.req_row;
            end
            if (w_ref_start) begin
               row_addr_d = ref_row_q;
               ref_row_d  = ref_row_q + ROW_BITS'(1);
               ref_busy_d = 1'b1;
            end
         end
         ACT: begin
            if (ph_q < c_ph_bits'(T_ACT - 1)) begin
               ph_d = ph_q + c_ph_bits'(1);
            end else begin
               state_d     = PRE;
               ph_d        = '0;
               decode_en_d = 1'b0;
               acc_done_d  = host_q;
            end
         end
         PRE: begin
            if (ph_q < c_ph_bits'(T_PRE - 1)) begin
               ph_d = ph_q + c_ph_bits'(1);
            end else begin
               state_d    = IDLE;
               ref_busy_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            decode_en_d = 1'b0;
            ref_busy_d  = 1'b0;
         end
      endcase

      // A tick landing on the same edge as a refresh start cancels out: the
      // new request replaces the one being served, so nothing is lost.
      if (w_tick && w_ref_start) begin
         pend_cnt_d = pend_cnt_q;
      end else if (w_tick) begin
         if (w_pend_full) begin
            ref_overflow_d = 1'b1;
         end else begin
            pend_cnt_d = pend_cnt_q + c_pend_bits'(1);
         end
      end else if (w_ref_start) begin
         pend_cnt_d = pend_cnt_q - c_pend_bits'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ph_q           <= '0;
         timer_q        <= '0;
         pend_cnt_q     <= '0;
         ref_overflow_q <= 1'b0;
         ref_row_q      <= '0;
         row_addr_q     <= '0;
         decode_en_q    <= 1'b0;
         ref_busy_q     <= 1'b0;
         acc_done_q     <= 1'b0;
         host_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ph_q           <= ph_d;
         timer_q        <= timer_d;
         pend_cnt_q     <= pend_cnt_d;
         ref_overflow_q <= ref_overflow_d;
         ref_row_q      <= ref_row_d;
         row_addr_q     <= row_addr_d;
         decode_en_q    <= decode_en_d;
         ref_busy_q     <= ref_busy_d;
         acc_done_q     <= acc_done_d;
         host_q         <= host_d;
      end
   end

   assign host.req_ready = w_req_ready;
   assign host.acc_done  = acc_done_q;
   assign row_addr       = row_addr_q;
   assign decode_en      = decode_en_q;
   assign ref_busy       = ref_busy_q;
   assign pend_cnt       = pend_cnt_q;
   assign ref_overflow   = ref_overflow_q;

endmodule
`default_nettype wire
